// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC register, imem request handshake, IF/ID register, stall/flush counters.
// IF/ID updates one cycle after a word is accepted; an outstanding request is never withdrawn, so stalls park the word in a hold buffer.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_IF_ID,
  input  logic        flush_IF,
  input  logic [1:0]  ID_PCSrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifIdReg_t;

  localparam ifIdReg_t BUBBLE = '{instr: NOP, pc4: 32'h0000_0000, valid: 1'b0};

  fetchState_t stateQ, stateNext;
  logic [31:0] pcQ, pcNext;
  logic [31:0] pendQ, pendNext;
  logic [31:0] holdInstrQ, holdInstrNext;
  logic [31:0] holdPcQ, holdPcNext;
  ifIdReg_t    ifIdQ, ifIdNext;

  logic [31:0] redirectTarget;
  logic [31:0] pcPlus4;
  logic [31:0] holdPcPlus4;
  logic        flushAccepted;

  // A flush raised during a stall is dropped; hazard logic re-raises it later.
  assign flushAccepted = flush_IF & ~stall_IF_ID;
  assign pcPlus4       = pcQ + 32'd4;
  assign holdPcPlus4   = holdPcQ + 32'd4;

  always_comb begin
    redirectTarget = branch_target;
    case (ID_PCSrc)
      2'b10:   redirectTarget = jump_target;
      2'b11:   redirectTarget = jr_target;
      default: redirectTarget = branch_target;
    endcase
  end

  // Moore outputs: depend only on state and PC, never on inputs.
  assign imem_req    = (stateQ != HOLD);
  assign imem_addr   = pcQ;
  assign IF_ID_Instr = ifIdQ.instr;
  assign IF_ID_PC4   = ifIdQ.pc4;
  assign IF_ID_Valid = ifIdQ.valid;

  always_comb begin
    stateNext     = stateQ;
    pcNext        = pcQ;
    pendNext      = pendQ;
    holdInstrNext = holdInstrQ;
    holdPcNext    = holdPcQ;
    ifIdNext      = ifIdQ;

    case (stateQ)
      FETCH: begin
        if (stall_IF_ID) begin
          // Memory answered under a stall: park the word rather than lose it.
          if (imem_ready) begin
            holdInstrNext = imem_rdata;
            holdPcNext    = pcQ;
            stateNext     = HOLD;
          end
        end else if (flush_IF) begin
          ifIdNext = BUBBLE;
          if (imem_ready) begin
            pcNext = redirectTarget;
          end else begin
            pendNext  = redirectTarget;
            stateNext = DISCARD;
          end
        end else if (imem_ready) begin
          ifIdNext = '{instr: imem_rdata, pc4: pcPlus4, valid: 1'b1};
          pcNext   = pcPlus4;
        end else begin
          ifIdNext = BUBBLE;
        end
      end

      HOLD: begin
        if (stall_IF_ID) begin
          stateNext = HOLD;
        end else if (flush_IF) begin
          ifIdNext  = BUBBLE;
          pcNext    = redirectTarget;
          stateNext = FETCH;
        end else begin
          ifIdNext  = '{instr: holdInstrQ, pc4: holdPcPlus4, valid: 1'b1};
          pcNext    = holdPcPlus4;
          stateNext = FETCH;
        end
      end

      DISCARD: begin
        // Old request stays on the bus until answered; its data is thrown away.
        if (!stall_IF_ID) begin
          ifIdNext = BUBBLE;
        end
        if (flushAccepted) begin
          pendNext = redirectTarget;
        end
        if (imem_ready) begin
          pcNext    = flushAccepted ? redirectTarget : pendQ;
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ     <= FETCH;
      pcQ        <= RESET_PC;
      pendQ      <= 32'h0000_0000;
      holdInstrQ <= 32'h0000_0000;
      holdPcQ    <= 32'h0000_0000;
      ifIdQ      <= BUBBLE;
    end else begin
      stateQ     <= stateNext;
      pcQ        <= pcNext;
      pendQ      <= pendNext;
      holdInstrQ <= holdInstrNext;
      holdPcQ    <= holdPcNext;
      ifIdQ      <= ifIdNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 32'h0000_0000;
      flush_count <= 32'h0000_0000;
    end else begin
      if (stall_IF_ID && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (flushAccepted && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: expected IF/ID contents are queued when stimulus is driven and compared after the edge.
// A second instance with RESET_PC=FFFF_FFFC and a non-zero NOP covers PC wrap and reset-from-HOLD.
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  pcSrc = 2'b00;
  logic [31:0] bt = 32'h0, jt = 32'h0, jrt = 32'h0;
  logic        ready = 1'b1;

  logic        req0, req1, valid0, valid1;
  logic [31:0] addr0, addr1, rdata0, rdata1;
  logic [31:0] instr0, instr1, pc40, pc41;
  logic [31:0] sc0, sc1, fc0, fc1;
  ifid_t       got0;

  int errors = 0;
  int checks = 0;
  ifid_t sb[$];
  ifid_t e;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign rdata0 = w(addr0);
  assign rdata1 = w(addr1);
  assign got0   = {instr0, pc40, valid0};

  if_fetch_ctrl dut0 (
    .clk(clk), .reset(reset), .stall_IF_ID(stall), .flush_IF(flush), .ID_PCSrc(pcSrc),
    .branch_target(bt), .jump_target(jt), .jr_target(jrt),
    .imem_req(req0), .imem_addr(addr0), .imem_ready(ready), .imem_rdata(rdata0),
    .IF_ID_Instr(instr0), .IF_ID_PC4(pc40), .IF_ID_Valid(valid0),
    .stall_count(sc0), .flush_count(fc0)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .NOP(32'h0000_0013)) dut1 (
    .clk(clk), .reset(reset), .stall_IF_ID(stall), .flush_IF(flush), .ID_PCSrc(pcSrc),
    .branch_target(bt), .jump_target(jt), .jr_target(jrt),
    .imem_req(req1), .imem_addr(addr1), .imem_ready(ready), .imem_rdata(rdata1),
    .IF_ID_Instr(instr1), .IF_ID_PC4(pc41), .IF_ID_Valid(valid1),
    .stall_count(sc1), .flush_count(fc1)
  );

  task automatic drive(input logic st, input logic fl, input logic [1:0] src, input logic rdy);
    stall = st;
    flush = fl;
    pcSrc = src;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (addr0 !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", addr0, 32'h0); end
    checks++; if (req0 !== 1'b1) begin errors++; $display("FAIL reset_req: got %b want 1", req0); end
    e = '{instr: 32'h0, pc4: 32'h0, valid: 1'b0};
    checks++; if (got0 !== e) begin errors++; $display("FAIL reset_ifid: got %h want %h", got0, e); end
    checks++; if (sc0 !== 32'h0 || fc0 !== 32'h0) begin errors++; $display("FAIL reset_counts: got %h/%h want 0/0", sc0, fc0); end
    checks++; if (addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr1: got %h want fffffffc", addr1); end
    checks++; if (instr1 !== 32'h13 || valid1 !== 1'b0) begin errors++; $display("FAIL reset_nop1: got %h/%b want 00000013/0", instr1, valid1); end
  endtask

  task automatic test_stream();
    doReset();
    for (int i = 0; i < 6; i++) begin
      checks++; if (addr0 !== 32'(4*i)) begin errors++; $display("FAIL stream_addr: got %h want %h", addr0, 32'(4*i)); end
      sb.push_back('{instr: w(32'(4*i)), pc4: 32'(4*i+4), valid: 1'b1});
      drive(1'b0, 1'b0, 2'b00, 1'b1);
      e = sb.pop_front();
      checks++; if (got0 !== e) begin errors++; $display("FAIL stream_ifid: got %h want %h", got0, e); end
    end
    sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL wait_bubble: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'd24) begin errors++; $display("FAIL wait_addr_hold: got %h want 18", addr0); end
    sb.push_back('{instr: w(32'd24), pc4: 32'd28, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL wait_resume: got %h want %h", got0, e); end
  endtask

  task automatic test_stall();
    doReset();
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{instr: w(32'(4*i)), pc4: 32'(4*i+4), valid: 1'b1});
      drive(1'b0, 1'b0, 2'b00, 1'b1);
      e = sb.pop_front();
      checks++; if (got0 !== e) begin errors++; $display("FAIL stall_pre: got %h want %h", got0, e); end
    end
    checks++; if (addr0 !== 32'd8) begin errors++; $display("FAIL stall_pc: got %h want 8", addr0); end
    for (int i = 1; i <= 2; i++) begin
      sb.push_back('{instr: w(32'd4), pc4: 32'd8, valid: 1'b1});
      drive(1'b1, 1'b0, 2'b00, 1'b1);
      e = sb.pop_front();
      checks++; if (got0 !== e) begin errors++; $display("FAIL stall_hold_ifid: got %h want %h", got0, e); end
      checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", req0); end
      checks++; if (sc0 !== 32'(i)) begin errors++; $display("FAIL stall_count: got %0d want %0d", sc0, i); end
    end
    sb.push_back('{instr: w(32'd8), pc4: 32'd12, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL stall_release: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'd12 || req0 !== 1'b1) begin errors++; $display("FAIL stall_next_addr: got %h/%b want 0000000c/1", addr0, req0); end
    checks++; if (sc0 !== 32'd2) begin errors++; $display("FAIL stall_count_final: got %0d want 2", sc0); end
  endtask

  task automatic test_flush_branch();
    doReset();
    bt = 32'h40; jt = 32'h300; jrt = 32'h500;
    sb.push_back('{instr: w(32'h0), pc4: 32'h4, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL br_pre: got %h want %h", got0, e); end
    sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    drive(1'b0, 1'b1, 2'b01, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL br_bubble: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h40) begin errors++; $display("FAIL br_target: got %h want 40", addr0); end
    checks++; if (fc0 !== 32'd1) begin errors++; $display("FAIL br_flush_count: got %0d want 1", fc0); end
    sb.push_back('{instr: w(32'h40), pc4: 32'h44, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL br_first: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h44) begin errors++; $display("FAIL br_next: got %h want 44", addr0); end
  endtask

  task automatic test_flush_wait();
    doReset();
    bt = 32'h44; jt = 32'h88; jrt = 32'h80;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{instr: w(32'(4*i)), pc4: 32'(4*i+4), valid: 1'b1});
      drive(1'b0, 1'b0, 2'b00, 1'b1);
      e = sb.pop_front();
      checks++; if (got0 !== e) begin errors++; $display("FAIL jr_pre: got %h want %h", got0, e); end
    end
    sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    drive(1'b0, 1'b1, 2'b11, 1'b0);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL jr_bubble: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h10 || req0 !== 1'b1) begin errors++; $display("FAIL jr_req_stable: got %h/%b want 00000010/1", addr0, req0); end
    checks++; if (fc0 !== 32'd1) begin errors++; $display("FAIL jr_flush_count: got %0d want 1", fc0); end
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
      drive(1'b0, 1'b0, 2'b00, 1'b0);
      e = sb.pop_front();
      checks++; if (got0 !== e) begin errors++; $display("FAIL jr_wait_bubble: got %h want %h", got0, e); end
      checks++; if (addr0 !== 32'h10) begin errors++; $display("FAIL jr_wait_addr: got %h want 10", addr0); end
    end
    sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL jr_discard: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h80) begin errors++; $display("FAIL jr_target: got %h want 80", addr0); end
    sb.push_back('{instr: w(32'h80), pc4: 32'h84, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL jr_first: got %h want %h", got0, e); end
  endtask

  task automatic test_stall_flush();
    doReset();
    bt = 32'h600; jt = 32'h200; jrt = 32'h700;
    sb.push_back('{instr: w(32'h0), pc4: 32'h4, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL sf_pre: got %h want %h", got0, e); end
    sb.push_back('{instr: w(32'h0), pc4: 32'h4, valid: 1'b1});
    drive(1'b1, 1'b1, 2'b10, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL sf_hold: got %h want %h", got0, e); end
    checks++; if (fc0 !== 32'd0 || sc0 !== 32'd1) begin errors++; $display("FAIL sf_counts_mid: got %0d/%0d want 0/1", fc0, sc0); end
    sb.push_back('{instr: 32'h0, pc4: 32'h0, valid: 1'b0});
    drive(1'b0, 1'b1, 2'b10, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL sf_bubble: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h200 || req0 !== 1'b1) begin errors++; $display("FAIL sf_target: got %h/%b want 00000200/1", addr0, req0); end
    sb.push_back('{instr: w(32'h200), pc4: 32'h204, valid: 1'b1});
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    e = sb.pop_front();
    checks++; if (got0 !== e) begin errors++; $display("FAIL sf_first: got %h want %h", got0, e); end
    checks++; if (addr0 !== 32'h204) begin errors++; $display("FAIL sf_next: got %h want 204", addr0); end
    checks++; if (fc0 !== 32'd1 || sc0 !== 32'd1) begin errors++; $display("FAIL sf_counts: got %0d/%0d want 1/1", fc0, sc0); end
  endtask

  task automatic test_wrap_reset();
    doReset();
    checks++; if (addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start: got %h want fffffffc", addr1); end
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    checks++; if (addr1 !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", addr1); end
    checks++; if (instr1 !== w(32'hFFFF_FFFC) || pc41 !== 32'h0 || valid1 !== 1'b1) begin
      errors++; $display("FAIL wrap_ifid: got %h/%h/%b want %h/00000000/1", instr1, pc41, valid1, w(32'hFFFF_FFFC));
    end
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL wrap_hold_req: got %b want 0", req1); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 1'b1);
    reset = 1'b0;
    checks++; if (addr1 !== 32'hFFFF_FFFC || req1 !== 1'b1) begin errors++; $display("FAIL hold_reset_addr: got %h/%b want fffffffc/1", addr1, req1); end
    checks++; if (instr1 !== 32'h13 || pc41 !== 32'h0 || valid1 !== 1'b0) begin
      errors++; $display("FAIL hold_reset_ifid: got %h/%h/%b want 00000013/00000000/0", instr1, pc41, valid1);
    end
    checks++; if (sc1 !== 32'h0) begin errors++; $display("FAIL hold_reset_count: got %0d want 0", sc1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_flush_branch();
    test_flush_wait();
    test_stall_flush();
    test_wrap_reset();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
